execute_stage: RTL and testbench

//  Sequential execute/writeback stage, directly downstream of the 16x16 register file.
//  - Accepts one instruction per issue handshake.
//  - Drives the register file read ports, captures operands, computes the result
//    (iterative for MUL), then writes the result back through the file's write port.
//  - One instruction is in flight at a time; issue_ready gates the upstream decoder.

---
 rtl/ex_pkg.sv | 40 ++++
 rtl/seq_multiplier.sv | 65 ++++++
 rtl/execute_stage.sv | 172 +++++++++++++++++
 tb/tb_execute_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ex_pkg.sv
// Shared constants for the execute stage: datapath defaults, opcodes, FSM states
// and opcode classification helpers.
package ex_pkg;

    localparam int DEF_DW     = 16;
    localparam int DEF_AW     = 4;
    localparam int DEF_MUL_IT = 16;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ADD = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4;
    localparam logic [3:0] OP_XOR = 4'h5;
    localparam logic [3:0] OP_NOT = 4'h6;
    localparam logic [3:0] OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8;
    localparam logic [3:0] OP_MOV = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_MUL = 4'hB;
    localparam logic [3:0] OP_CMP = 4'hC;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_EX,
        ST_MUL,
        ST_WB
    } state_e;

    // ADD through MUL are contiguous and are exactly the ops that write rd.
    function automatic logic op_writes(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MUL);
    endfunction

    function automatic logic op_illegal(input logic [3:0] op);
        return op > OP_CMP;
    endfunction

endpackage

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier: DW x DW -> 2*DW, one multiplier bit per cycle.
// The load cycle already performs the first iteration, so done pulses MUL_IT cycles after start.
module seq_multiplier #(
    parameter int DW     = 16,
    parameter int MUL_IT = 16
) (
    input  logic            clk,
    input  logic            nRESET,
    input  logic            start_i,
    input  logic [DW-1:0]   a_i,
    input  logic [DW-1:0]   b_i,
    output logic            done_o,
    output logic [2*DW-1:0] product_o
);

    localparam int CW = $clog2(MUL_IT + 1);

    logic [DW-1:0]   a_q;
    logic [2*DW-1:0] p_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q;
    logic            done_q;

    logic [2*DW-1:0] p_src;
    logic [DW-1:0]   a_src;
    logic [DW:0]     sum;
    logic [2*DW-1:0] p_next;

    always_comb begin
        p_src  = start_i ? {{DW{1'b0}}, b_i} : p_q;
        a_src  = start_i ? a_i : a_q;
        sum    = {1'b0, p_src[2*DW-1:DW]} + ({(DW+1){p_src[0]}} & {1'b0, a_src});
        p_next = {sum, p_src[DW-1:1]};
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            a_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i) begin
                a_q    <= a_i;
                p_q    <= p_next;
                cnt_q  <= CW'(MUL_IT - 1);
                busy_q <= (MUL_IT > 1);
                done_q <= (MUL_IT == 1);
            end else if (busy_q) begin
                p_q   <= p_next;
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o    = done_q;
    assign product_o = p_q;

endmodule

// File: rtl/execute_stage.sv
// Single-issue execute/writeback stage sitting behind a combinational-read register file.
// One instruction in flight: IDLE -> RD -> EX|MUL -> (WB) -> IDLE.
module execute_stage
    import ex_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW,
    parameter int MUL_IT = DEF_MUL_IT
) (
    input  logic          clk,
    input  logic          nRESET,
    input  logic          issue_valid,
    output logic          issue_ready,
    input  logic [3:0]    issue_op,
    input  logic [AW-1:0] issue_rd,
    input  logic [AW-1:0] issue_rs,
    input  logic [AW-1:0] issue_rt,
    input  logic [7:0]    issue_imm,
    output logic [AW-1:0] read_addrA,
    output logic [AW-1:0] read_addrB,
    input  logic [DW-1:0] read_dataA,
    input  logic [DW-1:0] read_dataB,
    output logic          write_en,
    output logic [AW-1:0] write_addr,
    output logic [DW-1:0] write_data,
    output logic          flag_z,
    output logic          flag_c,
    output logic          flag_v,
    output logic          illegal
);

    state_e state_q, state_d;

    logic [3:0]      op_q;
    logic [AW-1:0]   rd_q, rs_q, rt_q;
    logic [7:0]      imm_q;
    logic [DW-1:0]   opa_q, opb_q, wdata_q;
    logic            z_q, c_q, v_q;

    logic            mul_start, mul_done;
    logic [2*DW-1:0] mul_product;

    logic [DW:0]     sum, diff;
    logic [DW-1:0]   alu_res;
    logic            alu_c, alu_v, alu_upd;

    always_ff @(posedge clk) begin
        if (!nRESET) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (issue_valid) state_d = ST_RD;
            ST_RD:   state_d = (op_q == OP_MUL) ? ST_MUL : ST_EX;
            ST_EX:   state_d = op_writes(op_q) ? ST_WB : ST_IDLE;
            ST_MUL:  if (mul_done) state_d = ST_WB;
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        issue_ready = (state_q == ST_IDLE);
        write_en    = (state_q == ST_WB);
        illegal     = (state_q == ST_EX) && op_illegal(op_q);
        mul_start   = (state_q == ST_RD) && (op_q == OP_MUL);
    end

    // Carry/borrow come from the extra top bit of the widened sum/difference.
    always_comb begin
        sum     = {1'b0, opa_q} + {1'b0, opb_q};
        diff    = {1'b0, opa_q} - {1'b0, opb_q};
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_upd = 1'b1;
        case (op_q)
            OP_ADD: begin
                alu_res = sum[DW-1:0];
                alu_c   = sum[DW];
                alu_v   = (opa_q[DW-1] == opb_q[DW-1]) && (alu_res[DW-1] != opa_q[DW-1]);
            end
            OP_SUB, OP_CMP: begin
                alu_res = diff[DW-1:0];
                alu_c   = diff[DW];
                alu_v   = (opa_q[DW-1] != opb_q[DW-1]) && (alu_res[DW-1] != opa_q[DW-1]);
            end
            OP_AND:  alu_res = opa_q & opb_q;
            OP_OR:   alu_res = opa_q | opb_q;
            OP_XOR:  alu_res = opa_q ^ opb_q;
            OP_NOT:  alu_res = ~opa_q;
            OP_SHL:  alu_res = opa_q << opb_q[3:0];
            OP_SHR:  alu_res = opa_q >> opb_q[3:0];
            OP_MOV: begin
                alu_res = opa_q;
                alu_upd = 1'b0;
            end
            OP_LDI: begin
                alu_res = {{(DW-8){1'b0}}, imm_q};
                alu_upd = 1'b0;
            end
            default: alu_upd = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            op_q    <= OP_NOP;
            rd_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            imm_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            wdata_q <= '0;
            z_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
        end else begin
            if (issue_valid && issue_ready) begin
                op_q  <= issue_op;
                rd_q  <= issue_rd;
                rs_q  <= issue_rs;
                rt_q  <= issue_rt;
                imm_q <= issue_imm;
            end
            if (state_q == ST_RD) begin
                opa_q <= read_dataA;
                opb_q <= read_dataB;
            end
            if (state_q == ST_EX) begin
                wdata_q <= alu_res;
                if (alu_upd) begin
                    z_q <= (alu_res == '0);
                    c_q <= alu_c;
                    v_q <= alu_v;
                end
            end
            if ((state_q == ST_MUL) && mul_done) begin
                wdata_q <= mul_product[DW-1:0];
                z_q     <= (mul_product[DW-1:0] == '0);
                c_q     <= (mul_product[2*DW-1:DW] != '0);
                v_q     <= 1'b0;
            end
        end
    end

    // Operands go straight from the register file into the multiplier on its load edge.
    seq_multiplier #(
        .DW     (DW),
        .MUL_IT (MUL_IT)
    ) u_mul (
        .clk       (clk),
        .nRESET    (nRESET),
        .start_i   (mul_start),
        .a_i       (read_dataA),
        .b_i       (read_dataB),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    assign read_addrA = rs_q;
    assign read_addrB = rt_q;
    assign write_addr = rd_q;
    assign write_data = wdata_q;
    assign flag_z     = z_q;
    assign flag_c     = c_q;
    assign flag_v     = v_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with a behavioural 16x16 register file;
// a vector table covers single ops, hand-written sequences cover the multi-cycle corners.
module tb_execute_stage;

    localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3;
    localparam logic [3:0] OP_OR  = 4'h4, OP_XOR = 4'h5, OP_NOT = 4'h6, OP_SHL = 4'h7;
    localparam logic [3:0] OP_SHR = 4'h8, OP_MOV = 4'h9, OP_LDI = 4'hA, OP_MUL = 4'hB;
    localparam logic [3:0] OP_CMP = 4'hC;

    logic        clk = 1'b0;
    logic        nRESET;
    logic        issue_valid;
    logic        issue_ready;
    logic [3:0]  issue_op;
    logic [3:0]  issue_rd, issue_rs, issue_rt;
    logic [7:0]  issue_imm;
    logic [3:0]  read_addrA, read_addrB;
    logic [15:0] read_dataA, read_dataB;
    logic        write_en;
    logic [3:0]  write_addr;
    logic [15:0] write_data;
    logic        flag_z, flag_c, flag_v;
    logic        illegal;

    logic [15:0] regs [16];
    logic        preEn = 1'b0;
    logic [3:0]  preAddr = '0;
    logic [15:0] preData = '0;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rd, rs, rt;
        logic [7:0]  imm;
        int          expWb;
        logic [15:0] expData;
        int          expReady;
        logic        expZ, expC, expV;
        bit          expIll;
    } vec_t;

    vec_t tbl [18];

    always #5 clk = ~clk;

    execute_stage dut (
        .clk         (clk),
        .nRESET      (nRESET),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_op    (issue_op),
        .issue_rd    (issue_rd),
        .issue_rs    (issue_rs),
        .issue_rt    (issue_rt),
        .issue_imm   (issue_imm),
        .read_addrA  (read_addrA),
        .read_addrB  (read_addrB),
        .read_dataA  (read_dataA),
        .read_dataB  (read_dataB),
        .write_en    (write_en),
        .write_addr  (write_addr),
        .write_data  (write_data),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .flag_v      (flag_v),
        .illegal     (illegal)
    );

    assign read_dataA = regs[read_addrA];
    assign read_dataB = regs[read_addrB];

    always @(posedge clk) begin
        if (write_en)   regs[write_addr] <= write_data;
        else if (preEn) regs[preAddr]    <= preData;
    end

    function automatic vec_t mk(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs,
                                input logic [3:0] rt, input logic [7:0] imm, input int wb,
                                input logic [15:0] data, input int rdy, input logic z,
                                input logic c, input logic v, input bit ill);
        vec_t t;
        t.op = op; t.rd = rd; t.rs = rs; t.rt = rt; t.imm = imm;
        t.expWb = wb; t.expData = data; t.expReady = rdy;
        t.expZ = z; t.expC = c; t.expV = v; t.expIll = ill;
        return t;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [3:0] a, input logic [15:0] d);
        @(negedge clk);
        preEn = 1'b1; preAddr = a; preData = d;
        @(negedge clk);
        preEn = 1'b0;
    endtask

    task automatic driveIssue(input vec_t v);
        issue_valid = 1'b1;
        issue_op = v.op; issue_rd = v.rd; issue_rs = v.rs; issue_rt = v.rt; issue_imm = v.imm;
    endtask

    task automatic scrambleIssue();
        issue_valid = 1'b0;
        issue_op = 4'hF; issue_rd = 4'hF; issue_rs = 4'hF; issue_rt = 4'hF; issue_imm = 8'hEE;
    endtask

    // Issues one instruction and follows it cycle by cycle until issue_ready returns.
    task automatic applyStimulus(input string tag, input vec_t v);
        int wbCycle = 0, readyCycle = 0, illCount = 0, illCycle = 0;
        logic [3:0]  wAddr = '0;
        logic [15:0] wData = '0;
        @(negedge clk);
        checkOutput({tag, " readyBeforeIssue"}, issue_ready, 1);
        driveIssue(v);
        @(posedge clk);
        @(negedge clk);
        scrambleIssue();
        for (int k = 1; k <= 40; k++) begin
            if (write_en) begin
                wbCycle = k; wAddr = write_addr; wData = write_data;
            end
            if (illegal) begin
                illCount++; illCycle = k;
            end
            if (issue_ready) begin
                readyCycle = k;
                break;
            end
            @(negedge clk);
        end
        checkOutput({tag, " wbCycle"}, wbCycle, v.expWb);
        if (v.expWb != 0) begin
            checkOutput({tag, " writeAddr"}, wAddr, v.rd);
            checkOutput({tag, " writeData"}, wData, v.expData);
        end
        checkOutput({tag, " readyCycle"}, readyCycle, v.expReady);
        checkOutput({tag, " flagsZCV"}, {flag_z, flag_c, flag_v}, {v.expZ, v.expC, v.expV});
        checkOutput({tag, " illegalCount"}, illCount, v.expIll ? 1 : 0);
        if (v.expIll) checkOutput({tag, " illegalCycle"}, illCycle, 2);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int wb, acc, ldiWb, readyDuringMul, wrCount;
        logic [15:0] mulData, ldiData;
        logic [3:0]  ldiAddr;

        //                op      rd     rs     rt     imm    wb  data      rdy Z     C     V     ill
        tbl[0]  = mk(OP_LDI, 4'd0,  4'd0,  4'd0,  8'h96, 3,  16'h0096, 4,  1'b0, 1'b0, 1'b0, 0);
        tbl[1]  = mk(OP_LDI, 4'd1,  4'd0,  4'd0,  8'h69, 3,  16'h0069, 4,  1'b0, 1'b0, 1'b0, 0);
        tbl[2]  = mk(OP_ADD, 4'd2,  4'd0,  4'd1,  8'h00, 3,  16'h00FF, 4,  1'b0, 1'b0, 1'b0, 0);
        tbl[3]  = mk(OP_ADD, 4'd5,  4'd3,  4'd4,  8'h00, 3,  16'h0000, 4,  1'b1, 1'b1, 1'b0, 0);
        tbl[4]  = mk(OP_CMP, 4'd4,  4'd4,  4'd3,  8'h00, 0,  16'h0000, 3,  1'b0, 1'b1, 1'b0, 0);
        tbl[5]  = mk(OP_MUL, 4'd8,  4'd6,  4'd7,  8'h00, 18, 16'h1230, 19, 1'b0, 1'b0, 1'b0, 0);
        tbl[6]  = mk(OP_MUL, 4'd9,  4'd3,  4'd3,  8'h00, 18, 16'h0001, 19, 1'b0, 1'b1, 1'b0, 0);
        tbl[7]  = mk(OP_SUB, 4'd10, 4'd1,  4'd0,  8'h00, 3,  16'hFFD3, 4,  1'b0, 1'b1, 1'b0, 0);
        tbl[8]  = mk(OP_MOV, 4'd2,  4'd6,  4'd0,  8'h00, 3,  16'h0123, 4,  1'b0, 1'b1, 1'b0, 0);
        tbl[9]  = mk(OP_AND, 4'd12, 4'd0,  4'd1,  8'h00, 3,  16'h0000, 4,  1'b1, 1'b0, 1'b0, 0);
        tbl[10] = mk(OP_XOR, 4'd11, 4'd0,  4'd1,  8'h00, 3,  16'h00FF, 4,  1'b0, 1'b0, 1'b0, 0);
        tbl[11] = mk(OP_OR,  4'd13, 4'd0,  4'd4,  8'h00, 3,  16'h0097, 4,  1'b0, 1'b0, 1'b0, 0);
        tbl[12] = mk(OP_NOT, 4'd14, 4'd0,  4'd0,  8'h00, 3,  16'hFF69, 4,  1'b0, 1'b0, 1'b0, 0);
        tbl[13] = mk(OP_SHR, 4'd15, 4'd3,  4'd4,  8'h00, 3,  16'h7FFF, 4,  1'b0, 1'b0, 1'b0, 0);
        tbl[14] = mk(OP_SHL, 4'd12, 4'd6,  4'd4,  8'h00, 3,  16'h0246, 4,  1'b0, 1'b0, 1'b0, 0);
        tbl[15] = mk(OP_ADD, 4'd4,  4'd4,  4'd4,  8'h00, 3,  16'h0002, 4,  1'b0, 1'b0, 1'b0, 0);
        tbl[16] = mk(OP_CMP, 4'd0,  4'd1,  4'd1,  8'h00, 0,  16'h0000, 3,  1'b1, 1'b0, 1'b0, 0);
        tbl[17] = mk(OP_NOP, 4'd0,  4'd0,  4'd0,  8'h00, 0,  16'h0000, 3,  1'b1, 1'b0, 1'b0, 0);

        nRESET = 1'b0;
        scrambleIssue();
        repeat (3) @(negedge clk);
        nRESET = 1'b1;
        @(negedge clk);
        checkOutput("reset issueReady", issue_ready, 1);
        checkOutput("reset writeEn", write_en, 0);
        checkOutput("reset illegal", illegal, 0);
        checkOutput("reset flagsZCV", {flag_z, flag_c, flag_v}, 0);
        checkOutput("reset readAddrA", read_addrA, 0);
        checkOutput("reset writeData", write_data, 0);

        preload(4'd3, 16'hFFFF);
        preload(4'd4, 16'h0001);
        preload(4'd6, 16'h0123);
        preload(4'd7, 16'h0010);

        for (int i = 0; i < 18; i++)
            applyStimulus($sformatf("vec%0d", i), tbl[i]);
        checkOutput("regfile r15", regs[15], 16'h7FFF);

        // MUL with a second instruction held on the issue port the whole time.
        @(negedge clk);
        driveIssue(mk(OP_MUL, 4'd8, 4'd6, 4'd7, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        driveIssue(mk(OP_LDI, 4'd10, 4'd0, 4'd0, 8'h55, 0, 0, 0, 0, 0, 0, 0));
        wb = 0; acc = 0; readyDuringMul = 0; mulData = '0;
        for (int k = 1; k <= 40; k++) begin
            if (write_en && wb == 0) begin
                wb = k; mulData = write_data;
            end
            if (issue_ready) begin
                acc = k;
                break;
            end
            readyDuringMul++;
            @(negedge clk);
        end
        @(posedge clk);
        @(negedge clk);
        scrambleIssue();
        ldiWb = 0; ldiData = '0; ldiAddr = '0;
        for (int k = 1; k <= 10; k++) begin
            if (write_en && ldiWb == 0) begin
                ldiWb = k; ldiData = write_data; ldiAddr = write_addr;
            end
            @(negedge clk);
        end
        checkOutput("busyMul wbCycle", wb, 18);
        checkOutput("busyMul writeData", mulData, 16'h1230);
        checkOutput("busyMul readyCycle", acc, 19);
        checkOutput("busyMul busyCycles", readyDuringMul, 18);
        checkOutput("heldIssue wbCycle", ldiWb, 3);
        checkOutput("heldIssue writeAddr", ldiAddr, 10);
        checkOutput("heldIssue writeData", ldiData, 16'h0055);

        // Reset dropped in the middle of a MUL into r9.
        applyStimulus("preResetCmp", mk(OP_CMP, 4'd4, 4'd4, 4'd3, 8'h00, 0, 0, 3, 1'b0, 1'b1, 1'b0, 0));
        @(negedge clk);
        driveIssue(mk(OP_MUL, 4'd9, 4'd6, 4'd7, 8'h00, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        scrambleIssue();
        wrCount = 0;
        for (int k = 1; k < 8; k++) begin
            if (write_en) wrCount++;
            @(negedge clk);
        end
        nRESET = 1'b0;
        @(negedge clk);
        nRESET = 1'b1;
        checkOutput("midMulReset issueReady", issue_ready, 1);
        checkOutput("midMulReset flagsZCV", {flag_z, flag_c, flag_v}, 0);
        checkOutput("midMulReset readAddrA", read_addrA, 0);
        for (int k = 0; k < 25; k++) begin
            if (write_en) wrCount++;
            @(negedge clk);
        end
        checkOutput("midMulReset writeCount", wrCount, 0);
        checkOutput("midMulReset r9", regs[9], 16'h0001);

        // Unassigned opcode, then shift-by-zero.
        applyStimulus("preIllCmp", mk(OP_CMP, 4'd4, 4'd4, 4'd3, 8'h00, 0, 0, 3, 1'b0, 1'b1, 1'b0, 0));
        applyStimulus("illegalE", mk(4'hE, 4'd5, 4'd0, 4'd0, 8'h00, 0, 0, 3, 1'b0, 1'b1, 1'b0, 1));
        checkOutput("illegalE r5", regs[5], 16'h0000);
        applyStimulus("shlZero", mk(OP_SHL, 4'd1, 4'd0, 4'd7, 8'h00, 3, 16'h0096, 4, 1'b0, 1'b0, 1'b0, 0));
        @(negedge clk);
        checkOutput("shlZero r1", regs[1], 16'h0096);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
